rr_arbiter8: RTL
================

# rr_arbiter8

Eight-way round-robin arbiter that shares a single resource among eight requesters and drives the winner as both a one-hot grant vector (3-to-8 decoded) and a 3-bit index. It sits between the requesting units and the shared datapath: the index selects the datapath source, the one-hot vector returns the grant to the requester. The grant is held until the owner releases it or withdraws its request. Selection rotates fairly from the last winner.

## Interface
- HOLD_MAX, 15: maximum cycles a grant is held before forced release; legal range 1..255; used only with ARB_TIMEOUT_EN.

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request vector; bit k = requester k
- done  input  1  owner release strobe; sampled only while grant_valid=1
- grant  output  8  one-hot grant; equals decode(grant_num) when grant_valid=1, else 8'h00
- grant_num  output  3  index of current owner; holds last winner when idle
- grant_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

## Operation
- Reset (async, rst_n=0): state IDLE, grant=8'h00, grant_num=0, grant_valid=0, timeout=0, pointer ptr=0, hold counter=0.
- States: IDLE, GRANT.
- IDLE: if req≠0, pick first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8); on edge register winner into grant_num, set grant_valid=1, go GRANT, ptr←winner+1 (7 wraps to 0). If req=0, stay IDLE; all outputs unchanged except grant=0.
- GRANT: release on edge when done=1 or req[grant_num]=0 → IDLE, grant_valid=0, grant=0. No rearbitration in the release edge; at least one idle cycle always separates two grants.
- Requests from non-owners during GRANT are ignored (no preemption).
- grant is derived combinationally from registered grant_num/grant_valid; glitch-free w.r.t. inputs.
- Simultaneous done and timeout condition: done wins, timeout stays 0.
- Reset during GRANT: immediate return to reset values; ptr back to 0.

## Timing
- Arbitration latency: req sampled in IDLE at edge n → grant visible after edge n (1 cycle from request assertion).
- Release latency: done high at edge n → grant=0 after edge n.
- Minimum grant length 1 cycle; minimum turnaround owner→next owner 2 cycles (release edge + arbitration edge).
- Hold counter: cleared on entry to GRANT, +1 each GRANT cycle; saturates, 8-bit.

## Configuration
- ARB_TIMEOUT_EN defined: if the grant has been high HOLD_MAX cycles with no release, the next edge forces release → IDLE; timeout=1 for exactly the following cycle (the idle cycle). ptr already points past the owner, so the next requester wins afterwards.
- ARB_TIMEOUT_EN undefined: no counter, grant held indefinitely until done or request withdrawal; timeout tied 0.

## Test plan
- Reset: rst_n=0 with req=8'hFF, done=1 → grant=8'h00, grant_num=0, grant_valid=0, timeout=0; release rst_n → after 1 edge grant=8'b0000_0001.
- Single requester: req=8'b0000_1000 → next cycle grant=8'b0000_1000, grant_num=3; pulse done 1 cycle → grant=8'h00 next cycle, then regrant 3 one cycle later while req stays set.
- Fairness: req=8'hFF, done pulsed each grant cycle → grant_num sequence 0,1,2,…,7,0 with one idle cycle between each.
- Wrap and withdrawal: after owner 6 releases, req=8'h84 → grant_num=7 next; drop req[7] → release; then grant_num=2.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req=8'h03, no done → grant=8'h01 for exactly 4 cycles, timeout=1 for 1 cycle, then grant=8'h02; without macro grant=8'h01 stays 20+ cycles, timeout=0.
- Reset mid-grant: owner 5 active, rst_n=0 asynchronously between edges → grant=8'h00 immediately, grant_num=0; after release with req=8'h21 → grant_num=0 first (ptr reset).

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter, one-hot and indexed grant.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_num,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] win;
  logic [2:0] idx;
  logic       owner_rel;
  logic       force_rel;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter8: HOLD_MAX must be 1..255");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt;
  logic       tmo_q;

  assign force_rel = (hold_cnt == HOLD_LAST);
  assign timeout   = tmo_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Scan from the highest offset down so the
  // nearest set bit after ptr wins.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (req[idx]) win = idx;
    end
  end

  assign owner_rel = done || !req[grant_num];

  assign grant = grant_valid
               ? (8'b0000_0001 << grant_num)
               : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_num   <= 3'd0;
      grant_valid <= 1'b0;
      ptr         <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt    <= 8'd0;
      tmo_q       <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (|req) begin
            state       <= GRANT;
            grant_num   <= win;
            grant_valid <= 1'b1;
            ptr         <= win + 3'd1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (owner_rel) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end else if (force_rel) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q       <= 1'b1;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt != 8'hFF)
              hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
